seven_segment_scanner: RTL
==========================

Name: seven_segment_scanner

Overview:
- Time-multiplexes one shared hex-to-7-segment decoder across NUM_DIGITS common-anode-select digits.
- Owns digit sequencing, refresh timing, anti-ghosting blanking, frame-synchronous value update and optional leading-zero suppression.
- Sits between the system value source and the existing combinational decoder (nibble out, active-high segments a..g back, bit6=a) and drives the display pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; must be 2..8.
- REFRESH_DIV, 50000: clock cycles per digit slot; must be at least 2.
- BLANK_CYCLES, 500: cycles at the start of each slot with all anodes off; must be at least 1 and less than REFRESH_DIV.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  scanning enabled.
- value  in  4*NUM_DIGITS  display value; nibble i maps to digit i, where digit 0 is least significant.
- load  in  1  one-cycle strobe that captures value into the pending register.
- lz_suppress  in  1  blank leading zero digits.
- nib_out  out  4  nibble sent to the decoder; equals active nibble[idx].
- seg_in  in  7  decoder result, active-high, bit6=a … bit0=g.
- seg_out  out  7  segment drive, active-high.
- an_out  out  NUM_DIGITS  digit select, active-high, one-hot or zero.
- frame_done  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset state: state=IDLE, idx=0, cnt=0, pending=0, active=0, frame_done=0. an_out=0 and seg_out=0 immediately on rst_n low, without waiting for a clock edge.
- State registers: state {IDLE, BLANK, SHOW}, idx (digit index), cnt (slot counter, 0..REFRESH_DIV-1), pending, active, frame_done.
- Output decode:
  - an_out and seg_out are decoded from registers only.
  - SHOW and digit not suppressed: an_out = onehot(idx), seg_out = seg_in.
  - Otherwise: an_out = 0, seg_out = 0.
  - nib_out = active[4*idx+:4] in every state.
- load: on any clock with load=1, pending <= value. The last load before a boundary wins.
- IDLE:
  - Outputs dark.
  - enable=1 → BLANK, with idx=0, cnt=0 and active <= (load ? value : pending).
  - Does not pulse frame_done.
- BLANK:
  - cnt increments each cycle.
  - When cnt = BLANK_CYCLES-1 → SHOW.
- SHOW:
  - cnt increments each cycle.
  - When cnt = REFRESH_DIV-1 → BLANK with cnt=0, next slot.
- Slot timing: each slot is exactly REFRESH_DIV cycles, made up of BLANK_CYCLES dark cycles followed by REFRESH_DIV-BLANK_CYCLES lit cycles.
- Advance, normal: idx+1.
- Advance, frame boundary (idx = NUM_DIGITS-1):
  - idx wraps to 0.
  - active <= (load ? value : pending), so a load on the boundary cycle takes effect in the new frame.
  - frame_done=1 for the cycle following that edge.
  - A frame never mixes old and new values.
- enable=0 in any state: next edge → IDLE, idx=0, cnt=0. pending keeps updating on load.
- Leading-zero suppression:
  - Applies only when lz_suppress=1.
  - Digit i (i>0) is suppressed when active nibbles i..NUM_DIGITS-1 are all zero.
  - Digit 0 is never suppressed.
  - A suppressed slot keeps full timing but stays dark.
  - lz_suppress is sampled combinationally and may change at any time.
- Reset mid-slot aborts immediately. After release, the block restarts from IDLE.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
1. Assert rst_n=0 during SHOW of digit 2 → an_out=0 and seg_out=0 before the next clk edge. After release with enable=1, digit 0 begins with 2 dark cycles.
2. load value=16'h1234, enable=1 → per frame:
   - an_out=0001 for 6 cycles with seg_out=0110011 ("4").
   - Then 2 dark cycles.
   - an_out=0010 with seg_out=1111001 ("3").
   - an_out=0100 with 1101101 ("2").
   - an_out=1000 with 0110000 ("1").
   - frame_done pulses every 32 cycles.
3. lz_suppress=1 with value=16'h0050 → an_out is never 1000 or 0100; digit 1 shows 1011011 and digit 0 shows 1111110. With value=0 → only digit 0 is lit, showing 1111110.
4. Mid-frame load 16'hABCD, then load 16'hFFFF before the boundary → current frame unchanged. Next frame shows all digits as 1000111 ("F"), never "A" through "D".
5. load asserted exactly on the boundary cycle (idx=3, cnt=7) with 16'h0009 → the new frame's digit 0 shows 1111011 ("9").
6. Deassert enable during digit 1 SHOW → next cycle an_out=0 and seg_out=0, with no frame_done pulse. Reassert → restart at digit 0 with 2 blank cycles; first frame_done occurs 32 cycles later.

Source files
------------

// File: rtl/seven_segment_scanner.sv
// Scans NUM_DIGITS multiplexed digits through one shared external hex-to-7-segment
// decoder. It adds anti-ghosting blanking, frame-synchronous value update and leading-zero blanking.
module seven_segment_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic                    lz_suppress,
    output logic [3:0]              nib_out,
    input  logic [6:0]              seg_in,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_done
);

    localparam int VAL_W = 4 * NUM_DIGITS;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_SHOW
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [VAL_W-1:0]   pending_q, pending_d;
    logic [VAL_W-1:0]   active_q, active_d;
    logic               frame_done_q, frame_done_d;

    // upper_zero[i]: nibbles i..NUM_DIGITS-1 of the active value are all zero
    logic [NUM_DIGITS-1:1] upper_zero;
    logic [NUM_DIGITS-1:0] digit_blank;
    logic                  lit;

    assign upper_zero[NUM_DIGITS-1] = (active_q[VAL_W-1 -: 4] == 4'h0);
    assign digit_blank[0]           = 1'b0;

    generate
        for (genvar gi = 1; gi < NUM_DIGITS - 1; gi++) begin : g_zero_chain
            assign upper_zero[gi] = upper_zero[gi+1] && (active_q[4*gi +: 4] == 4'h0);
        end
        for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_blank
            assign digit_blank[gi] = upper_zero[gi];
        end
    endgenerate

    assign lit = (state_q == ST_SHOW) && !(lz_suppress && digit_blank[idx_q]);

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
            assign an_out[gi] = lit && (idx_q == IDX_W'(gi));
        end
    endgenerate

    assign seg_out    = lit ? seg_in : 7'b0;
    assign nib_out    = active_q[{idx_q, 2'b00} +: 4];
    assign frame_done = frame_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            pending_q    <= '0;
            active_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            active_q     <= active_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        active_d     = active_q;
        frame_done_d = 1'b0;
        // A load on the same edge as a frame start must land in the new frame
        pending_d    = load ? value : pending_q;

        if (!enable) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = ST_BLANK;
                    idx_d    = '0;
                    cnt_d    = '0;
                    active_d = pending_d;
                end
                ST_BLANK: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                        if (idx_q == LAST_IDX) begin
                            idx_d        = '0;
                            active_d     = pending_d;
                            frame_done_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

endmodule
